regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised, dual-write/dual-read general-purpose register file for the MIPS32 datapath, successor to the fixed 32x32 register file. It adds a second write port with deterministic priority, a per-register pending scoreboard for hazard detection in decode, and a sequential post-reset clear sweep, so the storage array needs no reset and can map to distributed RAM. It sits between decode (reads, issue marks) and writeback (writes).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 hardwired to zero: never written, never pending
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- init_busy  out  1  high while the clear sweep runs; all writes, issues and reads are blocked
- we0, waddr0, wdata0  in  1/ADDR_W/DATA_W  write port 0
- we1, waddr1, wdata1  in  1/ADDR_W/DATA_W  write port 1; has priority over port 0 on the same address
- re1, raddr1  in  1/ADDR_W  read port 1 enable and address
- rdata1  out  DATA_W  read port 1 data, combinational
- rd1_pending  out  1  register at raddr1 awaits a write
- re2, raddr2, rdata2, rd2_pending  as for port 1
- iss_valid, iss_addr  in  1/ADDR_W  marks iss_addr pending (instruction issued that will write it)
- debug_addr  in  ADDR_W  debug read address
- debug_data  out  DATA_W  raw stored value at debug_addr

## Operation
- State machine: INIT, READY. rst high at a clk edge forces INIT with clear counter cnt=0, pending all 0; valid from any state, including mid-sweep.
- INIT: each edge with rst low writes 0 to regs[cnt] and increments cnt. The edge at cnt==NUM_REGS-1 moves to READY. init_busy = (state==INIT) or rst.
- READY, writes: weN with waddrN accepted at the edge. With ZERO_REG=1, waddr 0 is dropped. If both ports target the same address, wdata1 is stored.
- Scoreboard: an accepted write clears pending[waddr]. iss_valid sets pending[iss_addr]. When issue and write hit the same address in one cycle, set wins (new producer). With ZERO_REG=1, iss to 0 is ignored.
- Reads, in priority order:
  - rst or init_busy: rdata=0, pending=0.
  - ZERO_REG and raddr==0: rdata=0, pending=0.
  - reN low: rdata=0, pending=0.
  - Otherwise: stored value, pending[raddr]. Forwarding is governed by Configuration.
- debug_data: unconditional regs[debug_addr], with no bypass and no gating. It is undefined before the first sweep completes.
- Storage array has no reset; only the sweep initialises it.

## Timing
- Reset values: init_busy=1, rdata1=rdata2=0, rd1_pending=rd2_pending=0, pending[]=0, state=INIT, cnt=0.
- Sweep length: init_busy falls exactly NUM_REGS edges after the first edge with rst low (32 for defaults).
- Write-to-read latency:
  - 0 cycles with bypass.
  - 1 edge without bypass.
- Issue-to-pending latency: 1 edge; rdN_pending is high from the cycle after iss_valid.
- Write-clear-to-pending latency: 0 cycles with bypass, 1 edge without.
- No handshake back-pressure: writes and issues presented while init_busy is high are discarded, not held.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose raddr matches an accepted write in the same cycle returns that write's data, with port 1 preferred on a dual match, and reports pending=0.
  - A same-cycle iss_valid to that address does not affect the current-cycle read.
- REGFILE_BYPASS_EN undefined: reads return stored regs[] and registered pending[] only. Writeback must precede decode by one cycle.

## Test plan
- Reset sweep: hold rst 3 cycles, release; init_busy stays 1 for exactly 32 edges. Then every raddr reads 0x00000000, pending 0.
- Dual write collision: we0=we1=1, waddr0=waddr1=5, wdata0=0x11111111, wdata1=0x22222222. Next cycle raddr1=5 gives 0x22222222.
- Zero register: write 0xDEADBEEF to reg 0 and issue to reg 0. Reading reg 0 gives 0, rd1_pending 0.
- Scoreboard: iss_addr=7. Next cycle rd1_pending=1 for raddr1=7. Write reg7=0xCAFEF00D:
  - With bypass: same cycle pending=0, data 0xCAFEF00D.
  - Without bypass: visible one cycle later.
- Issue/write same cycle on reg 9: pending[9] ends 1 and data is stored.
- Reset mid-sweep: assert rst at cnt=10; the sweep restarts from cnt=0, init_busy stays high a further 32 edges, and a write during the sweep is discarded.

Source files
------------

// File: rtl/regfile_mp.sv
// Dual-write / dual-read register file with a pending scoreboard and a post-reset clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rd1_pending,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              rd2_pending,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [ADDR_W-1:0] debug_addr,
    output logic [DATA_W-1:0] debug_data
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam bit          ZERO_HW  = (ZERO_REG != 0);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic ready_now;
    logic sweep_we;
    logic acc0;
    logic acc1;
    logic iss_acc;

    assign init_busy = (state == INIT) || rst;
    assign ready_now = (state == READY) && !rst;
    assign sweep_we  = (state == INIT) && !rst;

    assign acc0    = ready_now && we0 && !(ZERO_HW && (waddr0 == '0));
    assign acc1    = ready_now && we1 && !(ZERO_HW && (waddr1 == '0));
    assign iss_acc = ready_now && iss_valid && !(ZERO_HW && (iss_addr == '0));

    // Clears first, then the issue set, so a new producer wins over a retiring one.
    always_comb begin
        pending_nxt = pending;
        if (acc0)
            pending_nxt[waddr0] = 1'b0;
        if (acc1)
            pending_nxt[waddr1] = 1'b0;
        if (iss_acc)
            pending_nxt[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            cnt     <= '0;
            pending <= '0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == '1)
                        state <= READY;
                end
                READY: begin
                    pending <= pending_nxt;
                end
                default: begin
                    state <= INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep is its only initialisation. Port 1 overrides port 0.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            regs[cnt] <= '0;
        end else begin
            if (acc0)
                regs[waddr0] <= wdata0;
            if (acc1)
                regs[waddr1] <= wdata1;
        end
    end

    always_comb begin
        rdata1      = '0;
        rd1_pending = 1'b0;
        if (!init_busy && re1 && !(ZERO_HW && (raddr1 == '0))) begin
`ifdef REGFILE_BYPASS_EN
            if (acc1 && (waddr1 == raddr1)) begin
                rdata1 = wdata1;
            end else if (acc0 && (waddr0 == raddr1)) begin
                rdata1 = wdata0;
            end else begin
                rdata1      = regs[raddr1];
                rd1_pending = pending[raddr1];
            end
`else
            rdata1      = regs[raddr1];
            rd1_pending = pending[raddr1];
`endif
        end
    end

    always_comb begin
        rdata2      = '0;
        rd2_pending = 1'b0;
        if (!init_busy && re2 && !(ZERO_HW && (raddr2 == '0))) begin
`ifdef REGFILE_BYPASS_EN
            if (acc1 && (waddr1 == raddr2)) begin
                rdata2 = wdata1;
            end else if (acc0 && (waddr0 == raddr2)) begin
                rdata2 = wdata0;
            end else begin
                rdata2      = regs[raddr2];
                rd2_pending = pending[raddr2];
            end
`else
            rdata2      = regs[raddr2];
            rd2_pending = pending[raddr2];
`endif
        end
    end

    assign debug_data = regs[debug_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed steps from the test plan followed by random traffic,
// all checked against an array/counter reference model held in the bench.
module tb_regfile_mp;

    localparam int NUM = 32;

    logic        clk;
    logic        rst;
    logic        init_busy;
    logic        we0, we1, re1, re2, iss_valid;
    logic [4:0]  waddr0, waddr1, raddr1, raddr2, iss_addr, debug_addr;
    logic [31:0] wdata0, wdata1;
    logic [31:0] rdata1, rdata2, debug_data;
    logic        rd1_pending, rd2_pending;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .init_busy(init_busy),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .rd1_pending(rd1_pending),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2), .rd2_pending(rd2_pending),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .debug_addr(debug_addr), .debug_data(debug_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register contents, pending flags, edges of sweep still to go.
    logic [31:0] m_regs [NUM];
    logic        m_pend [NUM];
    int          sweep_left;

    int total;
    int passed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic bit m_busy();
        return rst || (sweep_left > 0);
    endfunction

    task automatic exp_read(input logic re, input logic [4:0] a,
                            output logic [31:0] d, output logic p);
        d = '0;
        p = 1'b0;
        if (!m_busy() && re && a != 0) begin
`ifdef REGFILE_BYPASS_EN
            if (we1 && waddr1 == a) d = wdata1;
            else if (we0 && waddr0 == a) d = wdata0;
            else begin
                d = m_regs[a];
                p = m_pend[a];
            end
`else
            d = m_regs[a];
            p = m_pend[a];
`endif
        end
    endtask

    // Check all outputs mid low phase, then advance one edge and update the model.
    task automatic cyc();
        logic [31:0] d;
        logic        p;
        #1;
        chk("init_busy", {31'b0, init_busy}, {31'b0, m_busy()});
        exp_read(re1, raddr1, d, p);
        chk("rdata1", rdata1, d);
        chk("rd1_pending", {31'b0, rd1_pending}, {31'b0, p});
        exp_read(re2, raddr2, d, p);
        chk("rdata2", rdata2, d);
        chk("rd2_pending", {31'b0, rd2_pending}, {31'b0, p});
        if (!m_busy())
            chk("debug_data", debug_data, m_regs[debug_addr]);
        @(posedge clk);
        if (rst) begin
            sweep_left = NUM;
            for (int i = 0; i < NUM; i++) m_pend[i] = 1'b0;
        end else if (sweep_left > 0) begin
            sweep_left--;
            if (sweep_left == 0)
                for (int i = 0; i < NUM; i++) m_regs[i] = '0;
        end else begin
            if (we0 && waddr0 != 0) begin m_regs[waddr0] = wdata0; m_pend[waddr0] = 1'b0; end
            if (we1 && waddr1 != 0) begin m_regs[waddr1] = wdata1; m_pend[waddr1] = 1'b0; end
            if (iss_valid && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; iss_valid = 0; re1 = 0; re2 = 0;
        waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
        raddr1 = 0; raddr2 = 0; iss_addr = 0; debug_addr = 0;
    endtask

    task automatic count_sweep(input string tag);
        int n;
        n = 0;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (!init_busy) break;
            cyc();
            n++;
        end
        chk(tag, n, 32);
    endtask

    initial begin
        total = 0;
        passed = 0;
        sweep_left = NUM;
        for (int i = 0; i < NUM; i++) begin m_regs[i] = '0; m_pend[i] = 1'b0; end
        idle();
        rst = 1;
        repeat (3) cyc();
        rst = 0;
        count_sweep("sweep_len");

        // Every register reads zero, nothing pending.
        for (int a = 0; a < NUM; a++) begin
            re1 = 1; raddr1 = 5'(a); re2 = 1; raddr2 = 5'(NUM - 1 - a); debug_addr = 5'(a);
            cyc();
        end

        // Dual write collision on reg 5.
        idle();
        we0 = 1; we1 = 1; waddr0 = 5; waddr1 = 5; wdata0 = 32'h1111_1111; wdata1 = 32'h2222_2222;
        cyc();
        idle();
        re1 = 1; raddr1 = 5; debug_addr = 5;
        #1 chk("collision", rdata1, 32'h2222_2222);
        cyc();

        // Register zero ignores writes and issues.
        idle();
        we0 = 1; waddr0 = 0; wdata0 = 32'hDEAD_BEEF; iss_valid = 1; iss_addr = 0; re1 = 1; raddr1 = 0;
        cyc();
        idle();
        re1 = 1; raddr1 = 0;
        #1 chk("zero_data", rdata1, 32'h0);
        chk("zero_pend", {31'b0, rd1_pending}, 32'h0);
        cyc();

        // Scoreboard on reg 7.
        idle();
        iss_valid = 1; iss_addr = 7;
        cyc();
        idle();
        re1 = 1; raddr1 = 7;
        #1 chk("sb_pend_set", {31'b0, rd1_pending}, 32'h1);
        cyc();
        we0 = 1; waddr0 = 7; wdata0 = 32'hCAFE_F00D;
`ifdef REGFILE_BYPASS_EN
        #1 chk("sb_bypass_data", rdata1, 32'hCAFE_F00D);
        chk("sb_bypass_pend", {31'b0, rd1_pending}, 32'h0);
`else
        #1 chk("sb_nobypass_pend", {31'b0, rd1_pending}, 32'h1);
`endif
        cyc();
        we0 = 0;
        #1 chk("sb_after_data", rdata1, 32'hCAFE_F00D);
        chk("sb_after_pend", {31'b0, rd1_pending}, 32'h0);
        cyc();

        // Issue and write on reg 9 in the same cycle.
        idle();
        we1 = 1; waddr1 = 9; wdata1 = 32'h0909_0909; iss_valid = 1; iss_addr = 9;
        cyc();
        idle();
        re2 = 1; raddr2 = 9; debug_addr = 9;
        #1 chk("iw_pend", {31'b0, rd2_pending}, 32'h1);
        chk("iw_data", rdata2, 32'h0909_0909);
        cyc();

        // Reset mid-sweep, with a write attempted during the restarted sweep.
        idle();
        rst = 1; cyc();
        rst = 0;
        repeat (10) cyc();
        rst = 1; cyc();
        rst = 0;
        for (int k = 0; k < 20; k++) cyc();
        we0 = 1; waddr0 = 3; wdata0 = 32'h3333_3333;
        cyc();
        idle();
        for (int k = 0; k < 60; k++) begin
            #1;
            if (!init_busy) break;
            cyc();
        end
        chk("midsweep_done", {31'b0, init_busy}, 32'h0);
        re1 = 1; raddr1 = 3; re2 = 1; raddr2 = 9; debug_addr = 3;
        #1 chk("midsweep_wr_dropped", rdata1, 32'h0);
        chk("midsweep_pend_clr", {31'b0, rd2_pending}, 32'h0);
        cyc();

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            rst        = ($urandom_range(299) == 0);
            we0        = $urandom_range(1);
            we1        = $urandom_range(1);
            waddr0     = 5'($urandom);
            waddr1     = ($urandom_range(3) == 0) ? waddr0 : 5'($urandom);
            wdata0     = $urandom;
            wdata1     = $urandom;
            iss_valid  = $urandom_range(1);
            iss_addr   = ($urandom_range(3) == 0) ? waddr0 : 5'($urandom);
            re1        = ($urandom_range(7) != 0);
            re2        = ($urandom_range(7) != 0);
            raddr1     = ($urandom_range(2) == 0) ? waddr1 : 5'($urandom);
            raddr2     = ($urandom_range(2) == 0) ? waddr0 : 5'($urandom);
            debug_addr = 5'($urandom);
            cyc();
        end
        rst = 0;
        idle();
        for (int k = 0; k < 40; k++) cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
